// File: rtl/lockin_demodulator.sv
// ---------------------------------------------------------------------------
// lockin_demodulator
//
// Phase-sensitive detector for the lock-in amplifier. Takes 8-bit unsigned
// ADC samples (midscale 128) and generates the square-wave excitation
// reference. Each sample is mixed with an in-phase and a quadrature square
// reference and summed over a window of SAMPLES_PER_PERIOD * 2^PERIODS_LOG2
// samples. The signed I/Q sums of each completed window go to the
// magnitude/phase stage.
//
// Ports
//   clk          in   1      system clock
//   reset        in   1      synchronous, active-high reset
//   enable       in   1      1 = run demodulation, 0 = idle / abandon window
//   sampleValid  in   1      one-cycle pulse, sampleData valid (any rate)
//   sampleData   in   8      unsigned ADC code, midscale 128
//   refOut       out  1      reference square wave (excitation drive)
//   refQuadOut   out  1      quadrature reference, 90 degrees lagging
//   busy         out  1      high while the demodulator is running
//   resultValid  out  1      one-cycle pulse, inPhase/quadrature updated
//   inPhase      out  ACC_W  signed I integral of the last completed window
//   quadrature   out  ACC_W  signed Q integral of the last completed window
// ---------------------------------------------------------------------------
module lockin_demodulator #(
    parameter  int SAMPLES_PER_PERIOD = 16,  // power of 2, >= 4
    parameter  int PERIODS_LOG2       = 4,   // window = 2^PERIODS_LOG2 periods
    localparam int ACC_W              = 9 + $clog2(SAMPLES_PER_PERIOD) + PERIODS_LOG2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sampleValid,
    input  logic [7:0]       sampleData,
    output logic             refOut,
    output logic             refQuadOut,
    output logic             busy,
    output logic             resultValid,
    output logic [ACC_W-1:0] inPhase,
    output logic [ACC_W-1:0] quadrature
);

    // Phase index width and window counter width. The phase is the low bits
    // of the window counter: both advance on every accepted sample and both
    // return to zero at the window end, so no separate phase register is kept.
    localparam int PH_W  = $clog2(SAMPLES_PER_PERIOD);
    localparam int CNT_W = PH_W + PERIODS_LOG2;

    typedef enum logic {
        IDLE,
        RUN
    } stateT;

    stateT                    state;
    logic [CNT_W-1:0]         sampleCnt;
    logic signed [ACC_W-1:0]  accI;
    logic signed [ACC_W-1:0]  accQ;

    logic [PH_W-1:0]          phase;
    logic                     iPos;
    logic                     qPos;
    logic signed [8:0]        sampleS;
    logic signed [ACC_W-1:0]  sampleExt;
    logic signed [ACC_W-1:0]  contribI;
    logic signed [ACC_W-1:0]  contribQ;
    logic signed [ACC_W-1:0]  sumI;
    logic signed [ACC_W-1:0]  sumQ;
    logic                     windowEnd;

    assign phase = sampleCnt[PH_W-1:0];

    // Reference signs from the two top phase bits. For SPP=16:
    //   I positive for p 0..7    -> top bit clear
    //   Q positive for p 4..11   -> top two bits differ
    assign iPos = ~phase[PH_W-1];
    assign qPos = phase[PH_W-1] ^ phase[PH_W-2];

    // Offset-binary to two's complement, range -128..+127, then sign-extend
    // to the accumulator width.
    assign sampleS   = $signed({1'b0, sampleData} - 9'd128);
    assign sampleExt = {{(ACC_W-9){sampleS[8]}}, sampleS};

    // Mixing with a +/-1 square reference is just add or subtract.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        contribI = sampleExt;
        contribQ = sampleExt;
        if (!iPos) begin
            contribI = -sampleExt;
        end
        if (!qPos) begin
            contribQ = -sampleExt;
        end
    end

    assign sumI = accI + contribI;
    assign sumQ = accQ + contribQ;

    // Last sample of the window: counter at its all-ones value.
    assign windowEnd = (sampleCnt == '1);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sampleCnt   <= '0;
            accI        <= '0;
            accQ        <= '0;
            refOut      <= 1'b0;
            refQuadOut  <= 1'b0;
            busy        <= 1'b0;
            resultValid <= 1'b0;
            inPhase     <= '0;
            quadrature  <= '0;
        end else begin
            resultValid <= 1'b0;

            case (state)
                IDLE: begin
                    // Held cleared; samples here, including the cycle that
                    // sees enable rise, are dropped.
                    sampleCnt  <= '0;
                    accI       <= '0;
                    accQ       <= '0;
                    refOut     <= 1'b0;
                    refQuadOut <= 1'b0;
                    if (enable) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end

                RUN: begin
                    if (!enable) begin
                        // Abandon the partial window; a sample arriving with
                        // enable low is ignored and the last results stay.
                        state      <= IDLE;
                        busy       <= 1'b0;
                        sampleCnt  <= '0;
                        accI       <= '0;
                        accQ       <= '0;
                        refOut     <= 1'b0;
                        refQuadOut <= 1'b0;
                    end else begin
                        // References follow the phase of the sample currently
                        // awaited, one register stage later.
                        refOut     <= iPos;
                        refQuadOut <= qPos;
                        if (sampleValid) begin
                            // Counter wraps to 0 on its own at the window end,
                            // which also returns the phase to 0.
                            sampleCnt <= sampleCnt + CNT_W'(1);
                            if (windowEnd) begin
                                inPhase     <= sumI;
                                quadrature  <= sumQ;
                                resultValid <= 1'b1;
                                accI        <= '0;
                                accQ        <= '0;
                            end else begin
                                accI <= sumI;
                                accQ <= sumQ;
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lockin_demodulator.sv
// ---------------------------------------------------------------------------
// tb_lockin_demodulator
//
// Directed bench for lockin_demodulator. Two instances share one stimulus
// stream: dut0 with a single-period window (16 samples) and dut1 with the
// default 256-sample window. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_lockin_demodulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sampleValid;
    logic [7:0]  sampleData;

    logic        refOut0, refQuadOut0, busy0, resultValid0;
    logic [12:0] inPhase0, quadrature0;
    logic        refOut1, refQuadOut1, busy1, resultValid1;
    logic [16:0] inPhase1, quadrature1;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int rv0Count    = 0;
    int rv1Count    = 0;
    int rv1Cycle[$];
    int rvBase;

    lockin_demodulator #(.SAMPLES_PER_PERIOD(16), .PERIODS_LOG2(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sampleValid(sampleValid),
        .sampleData (sampleData),
        .refOut     (refOut0),
        .refQuadOut (refQuadOut0),
        .busy       (busy0),
        .resultValid(resultValid0),
        .inPhase    (inPhase0),
        .quadrature (quadrature0)
    );

    lockin_demodulator #(.SAMPLES_PER_PERIOD(16), .PERIODS_LOG2(4)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sampleValid(sampleValid),
        .sampleData (sampleData),
        .refOut     (refOut1),
        .refQuadOut (refQuadOut1),
        .busy       (busy1),
        .resultValid(resultValid1),
        .inPhase    (inPhase1),
        .quadrature (quadrature1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Count result pulses; a stuck-high resultValid shows up as extra counts.
    always @(negedge clk) begin
        if (resultValid0 === 1'b1) rv0Count++;
        if (resultValid1 === 1'b1) begin
            rv1Count++;
            rv1Cycle.push_back(cycle);
        end
    end

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " refOut0"},      refOut0,               0);
        check({tag, " refQuadOut0"},  refQuadOut0,           0);
        check({tag, " busy0"},        busy0,                 0);
        check({tag, " resultValid0"}, resultValid0,          0);
        check({tag, " inPhase0"},     $signed(inPhase0),     0);
        check({tag, " quadrature0"},  $signed(quadrature0),  0);
        check({tag, " refOut1"},      refOut1,               0);
        check({tag, " refQuadOut1"},  refQuadOut1,           0);
        check({tag, " busy1"},        busy1,                 0);
        check({tag, " resultValid1"}, resultValid1,          0);
        check({tag, " inPhase1"},     $signed(inPhase1),     0);
        check({tag, " quadrature1"},  $signed(quadrature1),  0);
    endtask

    // kind 0: all midscale; 1: +100 for p0-7, -100 for p8-15; 2: swapped;
    // 3: +100 for p4-11, -100 elsewhere; 4: full scale 255 for p0-7, 0 else.
    function automatic logic [7:0] pat(input int kind, input int p);
        case (kind)
            1:       return (p < 8) ? 8'd228 : 8'd28;
            2:       return (p < 8) ? 8'd28 : 8'd228;
            3:       return (p >= 4 && p < 12) ? 8'd228 : 8'd28;
            4:       return (p < 8) ? 8'd255 : 8'd0;
            default: return 8'd128;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic sendSample(input logic [7:0] d, input int gap);
        sampleValid = 1'b1;
        sampleData  = d;
        @(negedge clk);
        sampleValid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic sendWindow(input int kind, input int n, input int gapMod);
        for (int i = 0; i < n; i++) begin
            sendSample(pat(kind, i % 16), (gapMod > 0) ? (i % gapMod) : 0);
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        sampleValid = 1'b0;
        sampleData  = 8'd0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");

        reset = 1'b0;
        @(negedge clk);
        check("idle busy0", busy0, 0);

        // Test 1: enable rises together with a sample that must be ignored.
        enable      = 1'b1;
        sampleValid = 1'b1;
        sampleData  = 8'd255;
        @(negedge clk);
        sampleValid = 1'b0;
        check("run busy0", busy0, 1);
        check("run busy1", busy1, 1);
        sendWindow(0, 16, 0);
        check("t1 resultValid0", resultValid0, 1);
        check("t1 inPhase0", $signed(inPhase0), 0);
        check("t1 quadrature0", $signed(quadrature0), 0);
        @(negedge clk);
        check("t1 pulse width", resultValid0, 0);
        settle();
        check("t1 rv0 count", rv0Count, 1);

        // Test 2: in-phase square, then inverted.
        sendWindow(1, 16, 0);
        check("t2 resultValid0", resultValid0, 1);
        check("t2 inPhase0", $signed(inPhase0), 1600);
        check("t2 quadrature0", $signed(quadrature0), 0);
        sendWindow(2, 16, 0);
        check("t2 inv inPhase0", $signed(inPhase0), -1600);
        check("t2 inv quadrature0", $signed(quadrature0), 0);

        // Test 3: quadrature square, references checked sample by sample.
        for (int p = 0; p < 16; p++) begin
            sendSample(pat(3, p), 0);
            check("t3 refOut0", refOut0, (p < 8) ? 1 : 0);
            check("t3 refQuadOut0", refQuadOut0, (p >= 4 && p < 12) ? 1 : 0);
        end
        check("t3 inPhase0", $signed(inPhase0), 0);
        check("t3 quadrature0", $signed(quadrature0), 1600);
        settle();
        check("t3 rv0 count", rv0Count, 4);

        // Realign dut1 (64 samples in) by a short idle.
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("idle busy1", busy1, 0);
        check("idle refOut1", refOut1, 0);
        check("idle refQuadOut1", refQuadOut1, 0);
        check("idle rv1 count", rv1Count, 0);
        enable = 1'b1;
        @(negedge clk);

        // Test 4: full-scale square, two back-to-back default windows.
        sendWindow(4, 256, 0);
        check("t4 resultValid1", resultValid1, 1);
        check("t4 inPhase1", $signed(inPhase1), 32640);
        check("t4 quadrature1", $signed(quadrature1), 0);
        check("t4 inPhase0", $signed(inPhase0), 2040);
        check("t4 quadrature0", $signed(quadrature0), 0);
        sendWindow(4, 256, 0);
        check("t4b resultValid1", resultValid1, 1);
        check("t4b inPhase1", $signed(inPhase1), 32640);
        check("t4b quadrature1", $signed(quadrature1), 0);
        settle();
        check("t4 rv1 count", rv1Count, 2);
        check("t4 rv1 spacing", rv1Cycle[1] - rv1Cycle[0], 256);

        // Test 5: abort after 100 samples; sample coinciding with enable=0.
        sendWindow(4, 100, 0);
        enable      = 1'b0;
        sampleValid = 1'b1;
        sampleData  = 8'd255;
        @(negedge clk);
        sampleValid = 1'b0;
        @(negedge clk);
        check("t5 busy1", busy1, 0);
        check("t5 refOut1", refOut1, 0);
        settle();
        check("t5 rv1 count", rv1Count, 2);
        check("t5 inPhase1 kept", $signed(inPhase1), 32640);
        enable = 1'b1;
        @(negedge clk);
        sendWindow(3, 256, 0);
        check("t5 resultValid1", resultValid1, 1);
        check("t5 inPhase1", $signed(inPhase1), 0);
        check("t5 quadrature1", $signed(quadrature1), 25600);
        check("t5 quadrature0", $signed(quadrature0), 1600);
        settle();
        check("t5 rv1 count after", rv1Count, 3);

        // Test 6: reset mid-window with gaps, then a gapped window.
        sendWindow(1, 5, 4);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("midreset");
        reset = 1'b0;
        @(negedge clk);
        rvBase = rv0Count;
        sendWindow(1, 16, 3);
        check("t6 resultValid0", resultValid0, 1);
        check("t6 inPhase0", $signed(inPhase0), 1600);
        check("t6 quadrature0", $signed(quadrature0), 0);
        settle();
        check("t6 rv0 count", rv0Count - rvBase, 1);
        check("t6 rv1 none", rv1Count, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
